// File: rtl/pf_lpddr3_lane_dly_ctrl_pkg.sv
// Shared encodings for the LPDDR3 lane delay-line sequencer: command ops, FSM states, direction.
// Pure declarations; no timing or handshake behaviour.
package pf_lpddr3_dly_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_ABS  = 2'b01,
      OP_INC  = 2'b10,
      OP_DEC  = 2'b11
   } dly_op_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_PULSE = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } dly_state_e;

   localparam logic DIR_INC = 1'b1;
   localparam logic DIR_DEC = 1'b0;

   // A single lane still needs a one-bit select so out-of-range lanes stay encodable.
   function automatic int lane_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pf_lpddr3_lane_dly_ctrl_if.sv
// Command/completion handshake plus IOD delay-line pins between fabric training logic and the sequencer.
// Signals only; slave is the sequencer, master is the training logic / IOD side.
interface pf_lpddr3_lane_dly_ctrl_if
   import pf_lpddr3_dly_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int TAP_W     = 8
);
   localparam int LANE_W = lane_w(NUM_LANES);

   logic                       cmd_valid;
   logic                       cmd_ready;
   logic [LANE_W-1:0]          cmd_lane;
   logic [1:0]                 cmd_op;
   logic [TAP_W-1:0]           cmd_val;
   logic                       done_valid;
   logic                       done_err;
   logic [TAP_W-1:0]           done_tap;
   logic [NUM_LANES*TAP_W-1:0] tap_cur;
   logic [NUM_LANES-1:0]       delay_line_load;
   logic [NUM_LANES-1:0]       delay_line_move;
   logic [NUM_LANES-1:0]       delay_line_direction;
   logic [NUM_LANES-1:0]       delay_line_out_of_range;

   modport slave (
      input  cmd_valid, cmd_lane, cmd_op, cmd_val, delay_line_out_of_range,
      output cmd_ready, done_valid, done_err, done_tap, tap_cur,
             delay_line_load, delay_line_move, delay_line_direction
   );

   modport master (
      output cmd_valid, cmd_lane, cmd_op, cmd_val, delay_line_out_of_range,
      input  cmd_ready, done_valid, done_err, done_tap, tap_cur,
             delay_line_load, delay_line_move, delay_line_direction
   );

endinterface

// File: rtl/pf_lpddr3_lane_dly_ctrl_tapfile.sv
// Per-lane tap register file, one write port, one combinational read port, reset to INIT_TAP.
// Write takes effect on the next edge; no backpressure.
module pf_lpddr3_dly_tapfile #(
   parameter int NUM_LANES = 2,
   parameter int TAP_W     = 8,
   parameter int INIT_TAP  = 1,
   parameter int LANE_W    = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [LANE_W-1:0]          wr_lane,
   input  logic [TAP_W-1:0]           wr_dat,
   input  logic [LANE_W-1:0]          rd_lane,
   output logic [TAP_W-1:0]           rd_dat,
   output logic [NUM_LANES*TAP_W-1:0] tap_flat
);
   localparam logic [TAP_W-1:0] INIT_T = TAP_W'(INIT_TAP);

   logic [TAP_W-1:0] tap_q [NUM_LANES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LANES; i++) tap_q[i] <= INIT_T;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_lane == LANE_W'(i)) tap_q[i] <= wr_dat;
         end
      end
   end

   // An unpopulated lane index reads back as zero.
   always_comb begin
      rd_dat = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (rd_lane == LANE_W'(i)) rd_dat = tap_q[i];
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_flat
      assign tap_flat[g*TAP_W +: TAP_W] = tap_q[g];
   end

endmodule

// File: rtl/pf_lpddr3_lane_dly_ctrl.sv
// Sequences tap commands into spaced single-cycle LOAD/MOVE pulses per IOD lane with clamping.
// DONE in cycle 2 + steps*(1+SETTLE_CYC) after accept; one command at a time, CMD_READY only in IDLE.
module pf_lpddr3_lane_dly_ctrl
   import pf_lpddr3_dly_pkg::*;
#(
   parameter int NUM_LANES  = 2,
   parameter int TAP_W      = 8,
   parameter int MAX_TAP    = 255,
   parameter int INIT_TAP   = 1,
   parameter int SETTLE_CYC = 3
) (
   input logic                      FAB_CLK,
   input logic                      ARST_N,
   pf_lpddr3_lane_dly_ctrl_if.slave bus
);
   localparam int LANE_W = lane_w(NUM_LANES);
   localparam int WCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(SETTLE_CYC - 1);
   localparam logic [TAP_W-1:0]  MAX_T     = TAP_W'(MAX_TAP);
   localparam logic [TAP_W-1:0]  INIT_T    = TAP_W'(INIT_TAP);
   localparam logic [TAP_W-1:0]  ONE_T     = TAP_W'(1);
   localparam logic [LANE_W:0]   LANE_LIM  = (LANE_W+1)'(NUM_LANES);

   dly_state_e           state_q, state_d;
   dly_op_e              op_q, op_d;
   logic [LANE_W-1:0]    lane_q, lane_d;
   logic [TAP_W-1:0]     val_q, val_d;
   logic [TAP_W-1:0]     steps_q, steps_d;
   logic                 err_q, err_d;
   logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
   logic [NUM_LANES-1:0] dir_q, dir_d;
   logic                 ready_q;

   logic                 lane_ok;
   logic [NUM_LANES-1:0] lane_oh;
   logic [TAP_W-1:0]     rd_tap;
   logic                 cur_dir;
   logic                 oor_hit;
   logic                 tap_we;
   logic [TAP_W-1:0]     tap_wd;
   logic [TAP_W-1:0]     steps_set;
   logic                 err_set;
   logic                 dir_set;
   logic [TAP_W-1:0]     headroom;
   logic                 is_pulse;

   assign lane_ok = ({1'b0, lane_q} < LANE_LIM);

   always_comb begin
      lane_oh = '0;
      for (int i = 0; i < NUM_LANES; i++) lane_oh[i] = (lane_q == LANE_W'(i));
   end

   assign cur_dir = |(dir_q & lane_oh);
   assign oor_hit = |(bus.delay_line_out_of_range & lane_oh);

   pf_lpddr3_dly_tapfile #(
      .NUM_LANES (NUM_LANES),
      .TAP_W     (TAP_W),
      .INIT_TAP  (INIT_TAP),
      .LANE_W    (LANE_W)
   ) u_tapfile (
      .clk      (FAB_CLK),
      .rst_n    (ARST_N),
      .wr_en    (tap_we),
      .wr_lane  (lane_q),
      .wr_dat   (tap_wd),
      .rd_lane  (lane_q),
      .rd_dat   (rd_tap),
      .tap_flat (bus.tap_cur)
   );

   // Step planning from the latched command; clamped requests still move as far as legal.
   always_comb begin
      steps_set = '0;
      err_set   = 1'b0;
      dir_set   = DIR_INC;
      headroom  = MAX_T - rd_tap;
      case (op_q)
         OP_LOAD: steps_set = ONE_T;
         OP_ABS: begin
            if (val_q > MAX_T) begin
               err_set = 1'b1;
            end else if (val_q >= rd_tap) begin
               steps_set = val_q - rd_tap;
            end else begin
               steps_set = rd_tap - val_q;
               dir_set   = DIR_DEC;
            end
         end
         OP_INC: begin
            if (val_q > headroom) begin
               steps_set = headroom;
               err_set   = 1'b1;
            end else begin
               steps_set = val_q;
            end
         end
         OP_DEC: begin
            dir_set = DIR_DEC;
            if (val_q > rd_tap) begin
               steps_set = rd_tap;
               err_set   = 1'b1;
            end else begin
               steps_set = val_q;
            end
         end
         default: steps_set = '0;
      endcase
      if (!lane_ok) begin
         steps_set = '0;
         err_set   = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      lane_d  = lane_q;
      val_d   = val_q;
      steps_d = steps_q;
      err_d   = err_q;
      wcnt_d  = wcnt_q;
      dir_d   = dir_q;
      tap_we  = 1'b0;
      tap_wd  = rd_tap;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid && ready_q) begin
               lane_d  = bus.cmd_lane;
               op_d    = dly_op_e'(bus.cmd_op);
               val_d   = bus.cmd_val;
               err_d   = 1'b0;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            steps_d = steps_set;
            err_d   = err_set;
            if (op_q != OP_LOAD) begin
               dir_d = (dir_q & ~lane_oh) | (lane_oh & {NUM_LANES{dir_set}});
            end
            state_d = (steps_set == '0) ? S_DONE : S_PULSE;
         end
         S_PULSE: begin
            wcnt_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (wcnt_q != WCNT_LAST) begin
               wcnt_d = wcnt_q + 1'b1;
            end else if (op_q == OP_LOAD) begin
               tap_we  = 1'b1;
               tap_wd  = INIT_T;
               steps_d = '0;
               state_d = S_DONE;
            end else if (oor_hit) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               tap_we  = 1'b1;
               tap_wd  = cur_dir ? (rd_tap + 1'b1) : (rd_tap - 1'b1);
               steps_d = steps_q - 1'b1;
               state_d = (steps_q == ONE_T) ? S_DONE : S_PULSE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         state_q <= S_IDLE;
         op_q    <= OP_LOAD;
         lane_q  <= '0;
         val_q   <= '0;
         steps_q <= '0;
         err_q   <= 1'b0;
         wcnt_q  <= '0;
         dir_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         lane_q  <= lane_d;
         val_q   <= val_d;
         steps_q <= steps_d;
         err_q   <= err_d;
         wcnt_q  <= wcnt_d;
         dir_q   <= dir_d;
         ready_q <= (state_d == S_IDLE);
      end
   end

   // Pulses decode straight from the state register so an async reset kills them immediately.
   assign is_pulse                 = (state_q == S_PULSE);
   assign bus.cmd_ready            = ready_q;
   assign bus.delay_line_load      = (is_pulse && op_q == OP_LOAD) ? lane_oh : '0;
   assign bus.delay_line_move      = (is_pulse && op_q != OP_LOAD) ? lane_oh : '0;
   assign bus.delay_line_direction = dir_q;
   assign bus.done_valid           = (state_q == S_DONE);
   assign bus.done_err             = bus.done_valid & err_q;
   assign bus.done_tap             = (bus.done_valid && lane_ok) ? rd_tap : '0;

endmodule

// File: tb/tb_pf_lpddr3_lane_dly_ctrl.sv
// Directed scoreboard bench: the driver queues hand-computed completions, a negedge monitor checks pulses and DONE.
module tb_pf_lpddr3_lane_dly_ctrl;
   import pf_lpddr3_dly_pkg::*;

   localparam int NL = 3;      // three lanes so that lane index 3 is encodable and invalid
   localparam int TW = 8;
   localparam int SP = 4;      // 1 + SETTLE_CYC

   typedef struct {
      int            acc;
      int            lane;
      int            moves;
      int            loads;
      logic          dir;
      logic          err;
      int            tap;
      logic [NL*TW-1:0] taps;
   } exp_t;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   mv_sel = 0, ld_sel = 0, other = 0;
   int   mtap [NL];
   int   rel;
   exp_t q[$];

   pf_lpddr3_lane_dly_ctrl_if #(.NUM_LANES(NL), .TAP_W(TW)) bus();

   pf_lpddr3_lane_dly_ctrl #(
      .NUM_LANES(NL), .TAP_W(TW), .MAX_TAP(255), .INIT_TAP(1), .SETTLE_CYC(3)
   ) dut (
      .FAB_CLK (clk),
      .ARST_N  (arst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [NL*TW-1:0] flat();
      logic [NL*TW-1:0] f;
      for (int i = 0; i < NL; i++) f[i*TW +: TW] = mtap[i][TW-1:0];
      return f;
   endfunction

   // Monitor: counts pulses for the head command and checks it when DONE appears.
   always @(negedge clk) begin
      if (arst_n && q.size() > 0) begin
         rel = cyc - q[0].acc + 1;
         for (int i = 0; i < NL; i++) begin
            if (bus.delay_line_move[i]) begin
               if (i == q[0].lane) begin
                  mv_sel++;
                  chk("move_dir", bus.delay_line_direction[i], q[0].dir);
                  chk("move_spacing", (rel - 2) % SP, 0);
               end else other++;
            end
            if (bus.delay_line_load[i]) begin
               if (i == q[0].lane) begin
                  ld_sel++;
                  chk("load_spacing", (rel - 2) % SP, 0);
               end else other++;
            end
         end
         if (bus.done_valid) begin
            chk("done_cycle", rel, 2 + (q[0].moves + q[0].loads) * SP);
            chk("done_err", bus.done_err, q[0].err);
            chk("done_tap", bus.done_tap, q[0].tap);
            chk("tap_cur", bus.tap_cur, q[0].taps);
            chk("move_count", mv_sel, q[0].moves);
            chk("load_count", ld_sel, q[0].loads);
            chk("stray_pulses", other, 0);
            void'(q.pop_front());
            mv_sel = 0; ld_sel = 0; other = 0;
         end
      end else if (arst_n && bus.done_valid) begin
         n_vec++;
         n_err++;
         $display("FAIL unexpected_done: DONE_VALID with no command outstanding (cycle %0d)", cyc);
      end
   end

   task automatic send(input int lane, input logic [1:0] op, input int val, input int moves,
                       input int loads, input logic dir, input logic err, input int tap,
                       output int acc);
      exp_t e;
      int   n;
      acc = cyc;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_lane  = lane[1:0];
      bus.cmd_op    = op;
      bus.cmd_val   = val[TW-1:0];
      n = 0;
      while (!bus.cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.cmd_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: CMD_READY low for %0d cycles, required high", n);
         bus.cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      acc = cyc;
      if (lane < NL) mtap[lane] = tap;
      e.acc = acc; e.lane = lane; e.moves = moves; e.loads = loads;
      e.dir = dir; e.err = err; e.tap = tap; e.taps = flat();
      q.push_back(e);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (q.size() > 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (q.size() > 0) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: %0d completions outstanding after %0d cycles, required 0", q.size(), n);
         q.delete();
      end
   endtask

   task automatic wait_rel(input int acc, input int target);
      while (cyc - acc + 1 < target) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish by 200000 time units");
      $fatal(1);
   end

   initial begin
      int acc;
      for (int i = 0; i < NL; i++) mtap[i] = 1;
      bus.cmd_valid = 1'b0;
      bus.cmd_lane  = '0;
      bus.cmd_op    = '0;
      bus.cmd_val   = '0;
      bus.delay_line_out_of_range = '0;

      // Reset state and CMD_READY one cycle after release.
      repeat (3) @(negedge clk);
      chk("rst_ready", bus.cmd_ready, 0);
      chk("rst_taps", bus.tap_cur, 24'h010101);
      chk("rst_pulses", {bus.delay_line_load, bus.delay_line_move}, 0);
      chk("rst_dir", bus.delay_line_direction, 0);
      chk("rst_done", {bus.done_valid, bus.done_err, bus.done_tap}, 0);
      arst_n = 1'b1;
      #1 chk("ready_before_edge", bus.cmd_ready, 0);
      @(negedge clk);
      chk("ready_after_release", bus.cmd_ready, 1);

      // lane, op, val, moves, loads, dir, err, expected done tap
      send(1, OP_ABS, 5,  4, 0, 1'b1, 1'b0, 5, acc);   wait_done();
      send(0, OP_ABS, 3,  2, 0, 1'b1, 1'b0, 3, acc);   wait_done();
      send(0, OP_DEC, 10, 3, 0, 1'b0, 1'b1, 0, acc);   wait_done();
      send(0, OP_ABS, 4,  4, 0, 1'b1, 1'b0, 4, acc);   wait_done();

      // Range flag raised during the third pulse's settle window stops the INC.
      send(0, OP_INC, 6,  3, 0, 1'b1, 1'b1, 6, acc);
      wait_rel(acc, 11);
      bus.delay_line_out_of_range = 3'b001;
      wait_done();
      bus.delay_line_out_of_range = '0;

      send(1, OP_ABS, 9,  4, 0, 1'b1, 1'b0, 9, acc);   wait_done();
      send(1, OP_LOAD, 0, 0, 1, 1'b1, 1'b0, 1, acc);   wait_done();
      send(3, OP_ABS, 5,  0, 0, 1'b1, 1'b1, 0, acc);   wait_done();
      send(2, OP_INC, 3,  3, 0, 1'b1, 1'b0, 4, acc);   wait_done();
      send(1, OP_ABS, 1,  0, 0, 1'b1, 1'b0, 1, acc);   wait_done();
      send(2, OP_INC, 255, 251, 0, 1'b1, 1'b1, 255, acc); wait_done();
      send(2, OP_INC, 0,  0, 0, 1'b1, 1'b0, 255, acc); wait_done();

      // Async reset in the second settle window of an ABS move.
      send(0, OP_ABS, 8,  2, 0, 1'b1, 1'b0, 8, acc);
      wait_rel(acc, 8);
      arst_n = 1'b0;
      #1;
      chk("midrst_pulses", {bus.delay_line_load, bus.delay_line_move}, 0);
      chk("midrst_taps", bus.tap_cur, 24'h010101);
      chk("midrst_dir", bus.delay_line_direction, 0);
      chk("midrst_ready", bus.cmd_ready, 0);
      chk("midrst_done", {bus.done_valid, bus.done_err}, 0);
      q.delete();
      mv_sel = 0; ld_sel = 0; other = 0;
      for (int i = 0; i < NL; i++) mtap[i] = 1;
      @(negedge clk);
      arst_n = 1'b1;
      send(0, OP_ABS, 3,  2, 0, 1'b1, 1'b0, 3, acc);   wait_done();

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
